display_scan_controller: RTL and testbench
==========================================

Name: display_scan_controller

Overview:
- Time-multiplexed scan driver for the 4-digit display path.
- Sits directly upstream of the 1-to-4 demultiplexer.
  - sel drives the demux 2-bit select.
  - demux_en drives the demux data input.
  - digit_code carries the BCD/hex nibble of the active digit to the segment decoder.
- Rotates through the four digit positions at a programmable rate.
- Inserts a blanking gap before each digit turns on, to prevent ghosting.
- Snapshots the four digit values once per frame, so a frame never shows a mix of old and new values.

Parameters:
- SLOT_CYCLES, 50000: total clock cycles per digit slot. Legal range is at least 2, and must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 1000: cycles at the start of each slot during which demux_en is held at 0. Legal range is at least 1.
- CNT_W, 16: slot counter width. Must satisfy 2^CNT_W >= SLOT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  scan run/stop control
- digits_in  in  16  four nibbles; [15:12] is the digit at sel=0, [3:0] is the digit at sel=3
- sel  out  2  demux select
- demux_en  out  1  demux data input; 1 turns the selected digit on
- digit_code  out  4  nibble of the currently selected digit
- frame_done  out  1  one-cycle pulse when a full 4-slot frame completes

Behaviour:
- Reset (asynchronous, active-high) takes effect immediately and clears everything:
  - state = IDLE
  - sel = 0, demux_en = 0, digit_code = 0, frame_done = 0
  - shadow register = 0, cnt = 0
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, BLANK, ON.
- IDLE:
  - demux_en = 0, sel = 0.
  - On an edge with enable=1: shadow <= digits_in, sel <= 0, digit_code <= digits_in[15:12], cnt <= 0, go to BLANK.
- BLANK:
  - demux_en = 0; cnt increments every cycle.
  - On the edge where cnt == BLANK_CYCLES-1: go to ON, demux_en <= 1, cnt <= cnt+1.
- ON:
  - demux_en = 1; cnt increments.
  - On the edge where cnt == SLOT_CYCLES-1: cnt <= 0, demux_en <= 0, go to BLANK.
  - If sel < 3: sel <= sel+1, and digit_code <= the shadow nibble for the new sel.
  - If sel == 3 (wrap-around):
    - sel <= 0
    - shadow <= digits_in; digit_code <= digits_in[15:12]
    - frame_done <= 1 for exactly one cycle
- Slot timing:
  - Each slot occupies exactly SLOT_CYCLES cycles.
  - Within a slot, demux_en is high for exactly SLOT_CYCLES-BLANK_CYCLES cycles.
  - A frame is 4*SLOT_CYCLES cycles.
- sel and digit_code change only on the same edge where demux_en falls (or while it is low). They never change while demux_en=1.
- Nibble mapping:
  - sel=0 → [15:12]; sel=1 → [11:8]; sel=2 → [7:4]; sel=3 → [3:0].
  - This matches the demux output ordering: sel=0 activates the leftmost digit.
- digits_in changes in mid-frame are ignored until the next wrap or the next IDLE→BLANK entry.
- enable deasserted in BLANK or ON:
  - Next edge: state IDLE, demux_en <= 0, sel <= 0, cnt <= 0, frame_done <= 0.
  - A partial frame never produces frame_done.
- Simultaneous terminal count and enable=0: enable wins. Go to IDLE with no frame_done.
- Reset asserted mid-slot: demux_en drops asynchronously. No residual pulse after release.

Test Plan (SLOT_CYCLES=8, BLANK_CYCLES=2):
1. Reset with enable=1 held → all outputs 0 during reset. After release, the first edge enters BLANK with sel=0.
2. digits_in=16'h1234, enable=1 for 40 cycles:
   - sel sequence 0,1,2,3, each held 8 cycles.
   - digit_code sequence 1,2,3,4.
   - demux_en high for 6 cycles per slot, preceded by 2 low cycles.
   - frame_done pulses once, 32 cycles after BLANK entry.
3. Change digits_in from 16'h1234 to 16'hABCD during slot sel=1 → rest of the frame shows 3,4; the next frame shows A,B,C,D.
4. Drop enable during the ON phase of sel=2 → next edge gives demux_en=0, sel=0, and no frame_done. Re-enable restarts at sel=0 with a fresh snapshot.
5. Drop enable on the same edge as the terminal count for sel=3 → IDLE entered, frame_done stays 0.
6. Assert reset mid-ON → demux_en=0 immediately, without waiting for a clock edge. After release, a clean restart with 2 blank cycles before demux_en=1.

Source files
------------

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan driver for a 4-digit display: walks sel 0..3, blanks the
// demux at the start of every slot and latches the four digit values once per frame.
module display_scan_controller #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] digits_in,
    output logic [1:0]  sel,
    output logic        demux_en,
    output logic [3:0]  digit_code,
    output logic        frame_done,
    output logic [1:0]  dbg_state
);

    // Handshake: none. enable is a level run/stop control sampled on every rising
    // edge; all outputs come straight from flops, so no input reaches an output
    // within the same cycle.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             demux_en_q, demux_en_d;
    logic [3:0]       digit_code_q, digit_code_d;
    logic             frame_done_q, frame_done_d;
    logic [15:0]      shadow_q, shadow_d;

    // sel=0 is the leftmost digit, held in the most significant nibble.
    function automatic logic [3:0] nibble_of(input logic [15:0] word, input logic [1:0] s);
        logic [3:0] n;
        case (s)
            2'd0:    n = word[15:12];
            2'd1:    n = word[11:8];
            2'd2:    n = word[7:4];
            default: n = word[3:0];
        endcase
        return n;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        demux_en_d   = demux_en_q;
        digit_code_d = digit_code_q;
        frame_done_d = 1'b0;
        shadow_d     = shadow_q;

        case (state_q)
            ST_IDLE: begin
                demux_en_d = 1'b0;
                sel_d      = 2'd0;
                if (enable) begin
                    shadow_d     = digits_in;
                    digit_code_d = digits_in[15:12];
                    cnt_d        = '0;
                    state_d      = ST_BLANK;
                end
            end

            ST_BLANK: begin
                if (!enable) begin
                    state_d    = ST_IDLE;
                    demux_en_d = 1'b0;
                    sel_d      = 2'd0;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        state_d    = ST_ON;
                        demux_en_d = 1'b1;
                    end
                end
            end

            ST_ON: begin
                // Losing enable takes priority over the slot terminal count, so a
                // partial frame can never raise frame_done.
                if (!enable) begin
                    state_d    = ST_IDLE;
                    demux_en_d = 1'b0;
                    sel_d      = 2'd0;
                    cnt_d      = '0;
                end else if (cnt_q == SLOT_LAST) begin
                    state_d    = ST_BLANK;
                    demux_en_d = 1'b0;
                    cnt_d      = '0;
                    if (sel_q == 2'd3) begin
                        sel_d        = 2'd0;
                        shadow_d     = digits_in;
                        digit_code_d = digits_in[15:12];
                        frame_done_d = 1'b1;
                    end else begin
                        sel_d        = sel_q + 2'd1;
                        digit_code_d = nibble_of(shadow_q, sel_q + 2'd1);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                demux_en_d = 1'b0;
                sel_d      = 2'd0;
                cnt_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sel_q        <= 2'd0;
            demux_en_q   <= 1'b0;
            digit_code_q <= 4'd0;
            frame_done_q <= 1'b0;
            shadow_q     <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            demux_en_q   <= demux_en_d;
            digit_code_q <= digit_code_d;
            frame_done_q <= frame_done_d;
            shadow_q     <= shadow_d;
        end
    end

    assign sel        = sel_q;
    assign demux_en   = demux_en_q;
    assign digit_code = digit_code_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: directed scenarios then random enable/data
// traffic, compared every cycle against a time-since-start model of the scan.
module tb_display_scan_controller;

    localparam int S = 8;
    localparam int B = 2;
    localparam int FRAME = 4 * S;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] digits_in;
    logic [1:0]  sel;
    logic        demux_en;
    logic [3:0]  digit_code;
    logic        frame_done;
    logic [1:0]  dbg_state;

    display_scan_controller #(
        .SLOT_CYCLES (S),
        .BLANK_CYCLES(B),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .digits_in (digits_in),
        .sel       (sel),
        .demux_en  (demux_en),
        .digit_code(digit_code),
        .frame_done(frame_done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;

    // Model: while running, m_t counts cycles since the scan started; slot,
    // blanking and frame boundaries all follow from it arithmetically.
    bit          m_active = 1'b0;
    int          m_t = 0;
    logic [15:0] m_snap = 16'd0;
    logic [3:0]  m_code = 4'd0;
    logic        m_fd = 1'b0;

    function automatic logic [3:0] nib(input logic [15:0] w, input int slot);
        logic [15:0] sh;
        sh = w >> (4 * (3 - slot));
        return sh[3:0];
    endfunction

    function automatic logic [1:0] exp_sel();
        return m_active ? 2'((m_t / S) % 4) : 2'd0;
    endfunction

    function automatic logic exp_en();
        return m_active && ((m_t % S) >= B);
    endfunction

    function automatic logic [1:0] exp_state();
        if (!m_active) return 2'd0;
        return ((m_t % S) < B) ? 2'd1 : 2'd2;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_t      = 0;
        m_snap   = 16'd0;
        m_code   = 4'd0;
        m_fd     = 1'b0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else if (!m_active) begin
            m_fd = 1'b0;
            if (enable) begin
                m_active = 1'b1;
                m_t      = 0;
                m_snap   = digits_in;
                m_code   = nib(digits_in, 0);
            end
        end else if (!enable) begin
            m_active = 1'b0;
            m_fd     = 1'b0;
        end else begin
            m_t  = m_t + 1;
            m_fd = ((m_t % FRAME) == 0);
            if (m_fd) m_snap = digits_in;
            m_code = nib(m_snap, (m_t / S) % 4);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sel"}, 32'(sel), 32'(exp_sel()));
        chk({tag, ".demux_en"}, 32'(demux_en), 32'(exp_en()));
        chk({tag, ".digit_code"}, 32'(digit_code), 32'(m_code));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(m_fd));
        chk({tag, ".state"}, 32'(dbg_state), 32'(exp_state()));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        if (frame_done === 1'b1) fd_count++;
    endtask

    // Advance until the model sits at the given position within the frame.
    task automatic run_until(input string tag, input int pos);
        bit reached;
        reached = (m_active && (m_t % FRAME) == pos);
        for (int i = 0; i < 2 * FRAME && !reached; i++) begin
            step(tag);
            reached = (m_active && (m_t % FRAME) == pos);
        end
        checks++;
        assert (reached) else begin
            errors++;
            $error("FAIL %s.wait: observed=not_reached expected=pos_%0d", tag, pos);
        end
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        digits_in = 16'h1234;
        model_reset();
        #1;
        check_all("t1_in_reset");
        step("t1_in_reset");
        step("t1_in_reset");
        reset = 1'b0;

        step("t1_first");
        chk("t1_blank_entry", 32'(dbg_state), 32'd1);
        chk("t1_sel0", 32'(sel), 32'd0);

        fd_count = 0;
        for (int i = 1; i < 40; i++) begin
            step("t2_scan");
            if (m_t == 2) chk("t2_first_on", 32'(demux_en), 32'd1);
            if (m_t == 8) chk("t2_code_slot1", 32'(digit_code), 32'h2);
            if (m_t == 31) chk("t2_code_slot3", 32'(digit_code), 32'h4);
            if (m_t == 32) chk("t2_frame_pulse", 32'(frame_done), 32'd1);
        end
        chk("t2_fd_count", 32'(fd_count), 32'd1);

        run_until("t3", 10);
        digits_in = 16'hABCD;
        run_until("t3", 24);
        chk("t3_old_snapshot", 32'(digit_code), 32'h4);
        run_until("t3", 0);
        chk("t3_new_snapshot", 32'(digit_code), 32'hA);

        run_until("t4", 19);
        fd_count = 0;
        enable = 1'b0;
        step("t4_drop");
        chk("t4_en_low", 32'(demux_en), 32'd0);
        chk("t4_sel0", 32'(sel), 32'd0);
        step("t4_idle");
        step("t4_idle");
        chk("t4_no_fd", 32'(fd_count), 32'd0);
        digits_in = 16'h5678;
        enable = 1'b1;
        step("t4_restart");
        chk("t4_fresh_code", 32'(digit_code), 32'h5);

        run_until("t5", 31);
        fd_count = 0;
        enable = 1'b0;
        step("t5_tc_drop");
        step("t5_idle");
        chk("t5_no_fd", 32'(fd_count), 32'd0);
        chk("t5_idle_state", 32'(dbg_state), 32'd0);

        enable = 1'b1;
        step("t6_start");
        run_until("t6", 4);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("t6_async");
        chk("t6_en_drop", 32'(demux_en), 32'd0);
        step("t6_in_reset");
        step("t6_in_reset");
        reset = 1'b0;
        step("t6_restart");
        step("t6_restart");
        chk("t6_still_blank", 32'(demux_en), 32'd0);
        step("t6_restart");
        chk("t6_on_after_gap", 32'(demux_en), 32'd1);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) enable = ~enable;
            if ($urandom_range(0, 9) == 0) digits_in = 16'($urandom);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
